mesi_bus_controller: RTL

//  Shared-bus responder for the per-line MESI cache FSMs. It is the far end of the

---
 rtl/mesi_bus_controller.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mesi_bus_controller.sv
`default_nettype none
// ============================================================================
// Module      : mesi_bus_controller
// Description : Shared-bus responder for per-line MESI cache controllers.
//               Round-robin arbitrates BusRd/BusRdX/BusUpgr requests, issues
//               one snoop per transaction, gathers the shared (C) and Flush
//               responses of the other caches, and drives the memory fill or
//               write-back before signalling completion to the requester.
// Ports       : clk, rstb               clock, async active-low reset
//               req_i/cmd_i/addr_i      per-cache request, command, line address
//               c_i/flush_i             per-cache snoop responses
//               gnt_o/snoop_src_o       one-hot grant (SNOOP..DONE)
//               bus_rd_o/bus_rdx_o/bus_upgr_o/snoop_addr_o  snoop broadcast
//               shared_o/done_o         completion to the granted cache
//               mem_req_o/mem_we_o/mem_addr_o/mem_ack_i     memory port
// Revision    : 1.0 - initial release
// ============================================================================
module mesi_bus_controller #(
  parameter int NUM_CACHES = 4,
  parameter int ADDR_W     = 16
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic [NUM_CACHES-1:0]        req_i,
  input  logic [2*NUM_CACHES-1:0]      cmd_i,
  input  logic [ADDR_W*NUM_CACHES-1:0] addr_i,
  input  logic [NUM_CACHES-1:0]        c_i,
  input  logic [NUM_CACHES-1:0]        flush_i,
  output logic [NUM_CACHES-1:0]        gnt_o,
  output logic                         bus_rd_o,
  output logic                         bus_rdx_o,
  output logic                         bus_upgr_o,
  output logic [ADDR_W-1:0]            snoop_addr_o,
  output logic [NUM_CACHES-1:0]        snoop_src_o,
  output logic                         shared_o,
  output logic                         done_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  input  logic                         mem_ack_i
);

  localparam int PTR_W = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;

  localparam logic [1:0] c_CMD_RD   = 2'b01;
  localparam logic [1:0] c_CMD_RDX  = 2'b10;
  localparam logic [1:0] c_CMD_UPGR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SNOOP = 2'd1,
    S_MEM   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_stateNext;
  logic [PTR_W-1:0]        r_ptr;
  logic [PTR_W-1:0]        r_gntIdx;
  logic [NUM_CACHES-1:0]   r_gnt;
  logic [1:0]              r_cmd;
  logic [ADDR_W-1:0]       r_addr;
  logic                    r_shared;
  logic                    r_flush;

  logic [NUM_CACHES-1:0]   w_elig;
  logic                    w_found;
  logic [PTR_W-1:0]        w_pickIdx;
  logic [NUM_CACHES-1:0]   w_pickGnt;
  logic [1:0]              w_pickCmd;
  logic [ADDR_W-1:0]       w_pickAddr;
  int                      w_cand;
  logic [PTR_W-1:0]        w_ptrNext;
  logic [ADDR_W-1:0]       w_addrOut;

  // A request carrying the "none" command is never eligible for a grant.
  for (genvar k = 0; k < NUM_CACHES; k++) begin : g_elig
    assign w_elig[k] = req_i[k] & (cmd_i[2*k +: 2] != 2'b00);
  end

  // Round-robin pick: scan from the pointer upwards, wrapping at NUM_CACHES.
  always_comb begin
    w_found    = 1'b0;
    w_pickIdx  = '0;
    w_pickGnt  = '0;
    w_pickCmd  = 2'b00;
    w_pickAddr = '0;
    w_cand     = 0;
    for (int i = 0; i < NUM_CACHES; i++) begin
      w_cand = int'(r_ptr) + i;
      if (w_cand >= NUM_CACHES) begin
        w_cand = w_cand - NUM_CACHES;
      end
      if (!w_found && w_elig[w_cand[PTR_W-1:0]]) begin
        w_found                          = 1'b1;
        w_pickIdx                        = w_cand[PTR_W-1:0];
        w_pickGnt[w_cand[PTR_W-1:0]]     = 1'b1;
        w_pickCmd                        = cmd_i[2*w_cand +: 2];
        w_pickAddr                       = addr_i[ADDR_W*w_cand +: ADDR_W];
      end
    end
  end

  assign w_ptrNext = (r_gntIdx == PTR_W'(NUM_CACHES-1)) ? '0 : r_gntIdx + PTR_W'(1);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_stateNext = S_SNOOP;
      // An upgrade already holds valid data, so it never touches memory.
      S_SNOOP: w_stateNext = (r_cmd == c_CMD_UPGR) ? S_DONE : S_MEM;
      S_MEM:   if (mem_ack_i) w_stateNext = S_DONE;
      S_DONE:  w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_ptr    <= '0;
      r_gntIdx <= '0;
      r_gnt    <= '0;
      r_cmd    <= 2'b00;
      r_addr   <= '0;
      r_shared <= 1'b0;
      r_flush  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt    <= w_pickGnt;
            r_gntIdx <= w_pickIdx;
            r_cmd    <= w_pickCmd;
            r_addr   <= w_pickAddr;
          end
        end
        S_SNOOP: begin
          // Caches answer combinationally during the snoop cycle; the
          // requester's own response bits are masked out.
          r_shared <= |(c_i & ~r_gnt);
          r_flush  <= |(flush_i & ~r_gnt);
        end
        S_DONE: begin
          r_gnt <= '0;
          r_ptr <= w_ptrNext;
        end
        default: ;
      endcase
    end
  end

  assign w_addrOut    = (r_state != S_IDLE) ? r_addr : '0;

  assign gnt_o        = r_gnt;
  assign snoop_src_o  = r_gnt;
  assign bus_rd_o     = (r_state == S_SNOOP) && (r_cmd == c_CMD_RD);
  assign bus_rdx_o    = (r_state == S_SNOOP) && (r_cmd == c_CMD_RDX);
  assign bus_upgr_o   = (r_state == S_SNOOP) && (r_cmd == c_CMD_UPGR);
  assign snoop_addr_o = w_addrOut;
  assign done_o       = (r_state == S_DONE);
  // Ownership requests never report sharing.
  assign shared_o     = (r_state == S_DONE) && (r_cmd == c_CMD_RD) && r_shared;
  assign mem_req_o    = (r_state == S_MEM);
  // With a flusher present the flushing cache supplies data; memory is only
  // updated by a write-back of that line.
  assign mem_we_o     = (r_state == S_MEM) && r_flush;
  assign mem_addr_o   = w_addrOut;

endmodule
`default_nettype wire
